// File: rtl/jtag_reg_bridge.sv
// JTAG user-chain register bridge: a shifted {op, addr, wdata} command issues one bus transfer on Update-DR.
// Optional bus timeout is enabled by defining JTAG_BRIDGE_TIMEOUT_EN.
module jtag_reg_bridge #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              JTCK,
  input  logic              JRSTN,
  input  logic              JTDI,
  input  logic              JSHIFT,
  input  logic              JUPDATE,
  input  logic              JRTI,
  input  logic              JCE,
  output logic              JTDO,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int unsigned SR_W = DATA_W + ADDR_W + 2;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  typedef enum logic {S_IDLE, S_REQ} state_e;

  state_e            state_q;
  logic [SR_W-1:0]   sr_q;
  logic              sel_q;
  logic              err_q;
  logic              done_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Run-Test/Idle carries no function here.
  logic unused_jrti;
  assign unused_jrti = JRTI;

  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              upd;

  // An update only belongs to this chain if we were shifted since the last one.
  assign cmd_op    = sr_q[SR_W-1 -: 2];
  assign cmd_addr  = sr_q[DATA_W +: ADDR_W];
  assign cmd_wdata = sr_q[DATA_W-1:0];
  assign upd       = JUPDATE && sel_q;

  assign JTDO      = sr_q[0];
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

`ifdef JTAG_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q;
`endif

  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      sel_q       <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      last_addr_q <= '0;
      rdata_q     <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifdef JTAG_BRIDGE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      if (JCE && JSHIFT) begin
        sr_q  <= {JTDI, sr_q[SR_W-1:1]};
        sel_q <= 1'b1;
      end else if (JCE) begin
        sr_q <= {err_q, done_q, last_addr_q, rdata_q};
      end
      if (upd) sel_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (upd) begin
            unique case (cmd_op)
              OP_WRITE, OP_READ: begin
                we_q        <= (cmd_op == OP_WRITE);
                addr_q      <= cmd_addr;
                wdata_q     <= cmd_wdata;
                last_addr_q <= cmd_addr;
                done_q      <= 1'b0;
                req_q       <= 1'b1;
                state_q     <= S_REQ;
`ifdef JTAG_BRIDGE_TIMEOUT_EN
                cnt_q       <= '0;
`endif
              end
              OP_CLR:  err_q <= 1'b0;
              OP_NOP:  ;
              default: ;
            endcase
          end
        end
        S_REQ: begin
          // A new command while busy is an overrun; the transfer in flight continues.
          if (upd) begin
            if (cmd_op == OP_WRITE || cmd_op == OP_READ) err_q <= 1'b1;
            else if (cmd_op == OP_CLR)                   err_q <= 1'b0;
          end
          if (bus_ack) begin
            if (!we_q) rdata_q <= bus_rdata;
            done_q  <= 1'b1;
            req_q   <= 1'b0;
            state_q <= S_IDLE;
          end
`ifdef JTAG_BRIDGE_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            if (!we_q) rdata_q <= '1;
            err_q   <= 1'b1;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_reg_bridge.sv
// Scoreboard bench for jtag_reg_bridge: bus transfers and captured words are checked against queued expectations.
module tb_jtag_reg_bridge;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned SR_W    = DATA_W + ADDR_W + 2;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                width;
  } bus_exp_t;

  logic              JTCK = 1'b0;
  logic              JRSTN, JTDI, JSHIFT, JUPDATE, JRTI, JCE;
  logic              JTDO, bus_req, bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  bus_exp_t        exp_bus_q[$];
  logic [SR_W-1:0] exp_cap_q[$];
  logic [SR_W-1:0] cap_obs;
  event            cap_done;

  logic              ack_en    = 1'b0;
  int                ack_delay = 1;
  logic [DATA_W-1:0] rsp_data  = '0;

  jtag_reg_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .JTCK(JTCK), .JRSTN(JRSTN), .JTDI(JTDI), .JSHIFT(JSHIFT), .JUPDATE(JUPDATE),
    .JRTI(JRTI), .JCE(JCE), .JTDO(JTDO), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 JTCK = ~JTCK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [SR_W-1:0] cmd(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                                          input logic [DATA_W-1:0] d);
    return {op, a, d};
  endfunction

  function automatic logic [SR_W-1:0] cap(input logic e, input logic dn, input logic [ADDR_W-1:0] a,
                                          input logic [DATA_W-1:0] d);
    return {e, dn, a, d};
  endfunction

  // Capture, shift in din while collecting JTDO, then Update-DR and idle in RTI.
  task automatic shift_dr(input logic [SR_W-1:0] din, input logic [SR_W-1:0] exp_cap);
    logic [SR_W-1:0] dout;
    exp_cap_q.push_back(exp_cap);
    JRTI = 1'b0; JCE = 1'b1; JSHIFT = 1'b0;
    @(negedge JTCK);
    JSHIFT = 1'b1;
    for (int i = 0; i < int'(SR_W); i++) begin
      dout[i] = JTDO;
      JTDI = din[i];
      @(negedge JTCK);
    end
    JCE = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0;
    JUPDATE = 1'b1;
    @(negedge JTCK);
    JUPDATE = 1'b0; JRTI = 1'b1;
    cap_obs = dout;
    -> cap_done;
    repeat (8) @(negedge JTCK);
  endtask

  // Bus responder: ack after ack_delay REQ cycles when enabled.
  initial begin
    int ack_cnt = 0;
    bus_ack = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge JTCK);
      if (bus_ack) begin
        bus_ack = 1'b0; ack_cnt = 0;
      end else if (bus_req && ack_en) begin
        ack_cnt++;
        if (ack_cnt >= ack_delay) begin
          bus_ack = 1'b1; bus_rdata = rsp_data;
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  // Bus monitor: pop on each request, check payload, stability and request width.
  initial begin
    logic     prev = 1'b0;
    logic     unstable = 1'b0;
    int       width = 0;
    bus_exp_t cur;
    forever begin
      @(negedge JTCK);
      if (bus_req && !prev) begin
        width = 1; unstable = 1'b0;
        if (exp_bus_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_req: got addr %h expected no request", bus_addr);
          cur = '{we: bus_we, addr: bus_addr, wdata: bus_wdata, width: 0};
        end else begin
          cur = exp_bus_q.pop_front();
          check("bus_we", 64'(bus_we), 64'(cur.we));
          check("bus_addr", 64'(bus_addr), 64'(cur.addr));
          check("bus_wdata", 64'(bus_wdata), 64'(cur.wdata));
        end
      end else if (bus_req) begin
        width++;
        if (bus_we !== cur.we || bus_addr !== cur.addr || bus_wdata !== cur.wdata) unstable = 1'b1;
      end else if (prev) begin
        check("bus_stable", 64'(unstable), 64'(0));
        if (cur.width != 0) check("req_width", 64'(width), 64'(cur.width));
      end
      prev = bus_req;
    end
  end

  // Capture monitor.
  initial begin
    logic [SR_W-1:0] e;
    forever begin
      @(cap_done);
      if (exp_cap_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL capture_unexpected: got %h expected none", cap_obs);
      end else begin
        e = exp_cap_q.pop_front();
        check("capture", 64'(cap_obs), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SR_W-1:0] st;
    JRSTN = 1'b0; JTDI = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0; JRTI = 1'b1; JCE = 1'b0;
    repeat (3) @(negedge JTCK);
    check("rst_jtdo", 64'(JTDO), 64'(0));
    check("rst_req", 64'(bus_req), 64'(0));
    check("rst_we", 64'(bus_we), 64'(0));
    check("rst_addr", 64'(bus_addr), 64'(0));
    check("rst_wdata", 64'(bus_wdata), 64'(0));
    JRSTN = 1'b1;
    @(negedge JTCK);

    // Fill the chain with ones, then reset mid-shift.
    JCE = 1'b1; JSHIFT = 1'b1; JTDI = 1'b1;
    repeat (SR_W + 3) @(negedge JTCK);
    check("shift_ones_jtdo", 64'(JTDO), 64'(1));
    JRSTN = 1'b0;
    #1;
    check("midshift_rst_jtdo", 64'(JTDO), 64'(0));
    check("midshift_rst_req", 64'(bus_req), 64'(0));
    @(negedge JTCK);
    JCE = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0;
    @(negedge JTCK);
    JRSTN = 1'b1;
    @(negedge JTCK);
    shift_dr(cmd(2'b00, 8'h00, 32'h0), '0);

    // Write with ack after 3 cycles.
    ack_en = 1'b1; ack_delay = 3;
    exp_bus_q.push_back('{we: 1'b1, addr: 8'h12, wdata: 32'hDEADBEEF, width: 3});
    shift_dr(cmd(2'b01, 8'h12, 32'hDEADBEEF), cap(1'b0, 1'b0, 8'h00, 32'h0));

    // Read with minimum latency.
    ack_delay = 1; rsp_data = 32'hCAFEF00D;
    exp_bus_q.push_back('{we: 1'b0, addr: 8'h34, wdata: 32'h11111111, width: 1});
    shift_dr(cmd(2'b10, 8'h34, 32'h11111111), cap(1'b0, 1'b1, 8'h12, 32'h0));

    // Foreign updates with this chain deselected.
    for (int i = 0; i < 3; i++) begin
      JUPDATE = 1'b1;
      @(negedge JTCK);
      JUPDATE = 1'b0;
      @(negedge JTCK);
      check("foreign_req", 64'(bus_req), 64'(0));
    end
    shift_dr(cmd(2'b00, 8'h00, 32'h0), cap(1'b0, 1'b1, 8'h34, 32'hCAFEF00D));

    // Overrun while ack is withheld, then clear.
    ack_en = 1'b0;
    exp_bus_q.push_back('{we: 1'b1, addr: 8'h56, wdata: 32'hA5A50F0F, width: 0});
    shift_dr(cmd(2'b01, 8'h56, 32'hA5A50F0F), cap(1'b0, 1'b1, 8'h34, 32'hCAFEF00D));
    shift_dr(cmd(2'b01, 8'h78, 32'h12345678), cap(1'b0, 1'b0, 8'h56, 32'hCAFEF00D));
    check("overrun_addr", 64'(bus_addr), 64'(8'h56));
    shift_dr(cmd(2'b11, 8'h00, 32'h0), cap(1'b1, 1'b0, 8'h56, 32'hCAFEF00D));
    ack_en = 1'b1; ack_delay = 1;
    repeat (4) @(negedge JTCK);
    st = cap(1'b0, 1'b1, 8'h56, 32'hCAFEF00D);

`ifdef JTAG_BRIDGE_TIMEOUT_EN
    ack_en = 1'b0;
    exp_bus_q.push_back('{we: 1'b0, addr: 8'h9A, wdata: 32'h0, width: int'(TIMEOUT)});
    shift_dr(cmd(2'b10, 8'h9A, 32'h0), st);
    repeat (TIMEOUT) @(negedge JTCK);
    check("timeout_req", 64'(bus_req), 64'(0));
    shift_dr(cmd(2'b11, 8'h00, 32'h0), cap(1'b1, 1'b0, 8'h9A, 32'hFFFFFFFF));
    st = cap(1'b0, 1'b0, 8'h9A, 32'hFFFFFFFF);
`endif

    // Reset in the middle of a transfer drops the request at once.
    ack_en = 1'b0;
    exp_bus_q.push_back('{we: 1'b1, addr: 8'hBC, wdata: 32'h0BADCAFE, width: 0});
    shift_dr(cmd(2'b01, 8'hBC, 32'h0BADCAFE), st);
    check("req_before_rst", 64'(bus_req), 64'(1));
    JRSTN = 1'b0;
    #1;
    check("midreq_rst_req", 64'(bus_req), 64'(0));
    check("midreq_rst_we", 64'(bus_we), 64'(0));
    check("midreq_rst_addr", 64'(bus_addr), 64'(0));
    repeat (2) @(negedge JTCK);
    JRSTN = 1'b1;
    @(negedge JTCK);
    shift_dr(cmd(2'b00, 8'h00, 32'h0), '0);

    repeat (5) @(negedge JTCK);
    check("bus_queue_empty", 64'(exp_bus_q.size()), 64'(0));
    check("cap_queue_empty", 64'(exp_cap_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
